// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - fpu opcodes, abort value and issue-controller state encoding
package fpu_pkg;

   localparam logic [1:0]  FPU_OP_ADD = 2'b00;
   localparam logic [1:0]  FPU_OP_SUB = 2'b01;
   localparam logic [1:0]  FPU_OP_MUL = 2'b10;
   localparam logic [1:0]  FPU_OP_DIV = 2'b11;

   localparam logic [31:0] FPU_QNAN   = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      RESP  = 2'd3
   } issue_state_t;

endpackage

// File: rtl/fpu_issue_timer.sv
// rtl/fpu_issue_timer.sv - loadable watchdog counter with clear, enable and expired flag
module fpu_issue_timer
   import fpu_pkg::*;
#(
   parameter int LIMIT = 32,
   parameter int W     = $clog2(LIMIT) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         expired
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Flags the last permitted wait cycle, so the abort lands on that same edge.
   assign expired = (count == LAST);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - single-outstanding fpu issue controller with reset/start sequencing and watchdog
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 32,
   parameter int TAG_W          = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             fpu_rst,
   output logic             fpu_start,
   output logic [1:0]       fpu_op,
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   input  logic [31:0]      fpu_r,
   input  logic             fpu_done,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_r,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   issue_state_t state, state_next;
   logic         accept;
   logic         expired;

   // Handshake outputs decode straight from state so an async reset drops them at once.
   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign fpu_rst   = (state == CLEAR);
   assign fpu_start = (state == RUN);
   assign rsp_valid = (state == RESP);

   fpu_issue_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .W     (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (fpu_rst),
      .load       (1'b0),
      .load_value ({CNT_W{1'b0}}),
      .enable     (fpu_start),
      .expired    (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept)              state_next = CLEAR;
         CLEAR:                            state_next = RUN;
         RUN:     if (fpu_done || expired) state_next = RESP;
         RESP:    if (rsp_ready)           state_next = IDLE;
         default:                          state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpu_op      <= '0;
         fpu_a       <= '0;
         fpu_b       <= '0;
         rsp_tag     <= '0;
         rsp_r       <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         if (accept) begin
            fpu_op  <= req_op;
            fpu_a   <= req_a;
            fpu_b   <= req_b;
            rsp_tag <= req_tag;
         end
         // fpu_done is only trusted in RUN; a stale done seen during CLEAR is never captured.
         if (state == RUN) begin
            if (fpu_done) begin
               rsp_r       <= fpu_r;
               rsp_timeout <= 1'b0;
            end else if (expired) begin
               rsp_r       <= FPU_QNAN;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed and randomized bench for fpu_issue_ctrl with an fpu model
module tb_fpu_issue_ctrl;
   import fpu_pkg::*;

   localparam int TO = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_tag;
   logic        fpu_rst, fpu_start;
   logic [1:0]  fpu_op;
   logic [31:0] fpu_a, fpu_b, fpu_r;
   logic        fpu_done;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_r;
   logic [4:0]  rsp_tag;
   logic        rsp_timeout;

   int compared   = 0;
   int mismatched = 0;
   int m_delay    = 0;
   bit m_stale    = 1'b0;
   int m_cnt      = 0;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .fpu_rst(fpu_rst), .fpu_start(fpu_start), .fpu_op(fpu_op),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_r(fpu_r), .fpu_done(fpu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
      .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
   );

   // Arithmetic of the modelled fpu: exact IEEE results for the directed cases, a mixing function otherwise.
   function automatic logic [31:0] fpu_func(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == FPU_OP_ADD && a == 32'h41C00000 && b == 32'h40C00000) return 32'h41F00000;
      if (op == FPU_OP_ADD && a == 32'h3F400000 && b == 32'h40100000) return 32'h40400000;
      if (op == FPU_OP_ADD && a == 32'h412C0000 && b == 32'h3F933333) return 32'h413E6666;
      return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
   endfunction

   // fpu model: done after m_delay start cycles (never if m_delay<=0); stale mode holds done until fpu_rst.
   always @(negedge clk) begin
      if (rst || fpu_rst) begin
         m_cnt    = 0;
         fpu_done = 1'b0;
      end else if (fpu_start) begin
         m_cnt = m_cnt + 1;
         if (m_delay > 0 && m_cnt >= m_delay) begin
            fpu_done = 1'b1;
            fpu_r    = fpu_func(fpu_op, fpu_a, fpu_b);
         end
      end else if (!m_stale) begin
         fpu_done = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where the controller is back in IDLE.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int delay, input int bp, input bit hold);
      int          n;
      int          lat;
      int          elat;
      logic [31:0] er;
      logic        eto;
      m_delay = delay;
      if (delay >= 1 && delay <= TO) begin
         er = fpu_func(op, a, b); eto = 1'b0; elat = 2 + delay;
      end else begin
         er = FPU_QNAN; eto = 1'b1; elat = 2 + TO;
      end
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk); n++;
      end
      chk("accept_wait", 32'(n < 100), 32'd1);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      chk("clear_ctl", {fpu_rst, fpu_start, req_ready, rsp_valid}, 4'b1000);
      chk("latch_a", fpu_a, a);
      chk("latch_b", fpu_b, b);
      chk("latch_op", fpu_op, op);
      @(negedge clk);
      lat = 2;
      chk("run_entry", {fpu_rst, fpu_start}, 2'b01);
      while (!rsp_valid && lat < 60) begin
         chk("run_ctl", {fpu_start, fpu_rst, req_ready}, 3'b100);
         chk("run_opnd", fpu_a ^ fpu_b, a ^ b);
         @(negedge clk); lat++;
      end
      chk("latency", lat, elat);
      chk("rsp_r", rsp_r, er);
      chk("rsp_tag", rsp_tag, tag);
      chk("rsp_timeout", rsp_timeout, eto);
      chk("resp_ctl", {rsp_valid, fpu_start, req_ready}, 3'b100);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_ctl", {rsp_valid, fpu_start, req_ready}, 3'b100);
         chk("bp_r", rsp_r, er);
         chk("bp_tag", rsp_tag, tag);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_after", {rsp_valid, req_ready, fpu_start}, 3'b010);
   endtask

   initial begin
      int          seen;
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      logic [4:0]  r_tag;
      int          r_delay, r_bp;
      bit          r_hold;

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
      rsp_ready = 1'b0; fpu_r = '0; fpu_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {req_ready, fpu_rst, fpu_start, rsp_valid, rsp_timeout}, 5'b00000);
      chk("rst_data", fpu_a | fpu_b | rsp_r, 32'd0);
      chk("rst_tag_op", {rsp_tag, fpu_op}, 7'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1'b1);

      do_op(FPU_OP_ADD, 32'h41C00000, 32'h40C00000, 5'd7, 12, 0, 1'b0);

      do_op(FPU_OP_ADD, 32'h3F400000, 32'h40100000, 5'd3, 5, 0, 1'b1);
      do_op(FPU_OP_ADD, 32'h412C0000, 32'h3F933333, 5'd4, 7, 0, 1'b1);
      req_valid = 1'b0;

      do_op(FPU_OP_SUB, 32'h12345678, 32'h9ABCDEF0, 5'd21, 1, 0, 1'b0);
      do_op(FPU_OP_MUL, 32'hCAFEF00D, 32'h0BADBEEF, 5'd9, -1, 0, 1'b0);
      do_op(FPU_OP_MUL, 32'h11112222, 32'h33334444, 5'd10, TO, 0, 1'b0);
      do_op(FPU_OP_DIV, 32'h55556666, 32'h77778888, 5'd11, TO + 1, 0, 1'b0);
      do_op(FPU_OP_SUB, 32'hDEADBEEF, 32'h01234567, 5'd12, 4, 5, 1'b0);

      m_stale = 1'b1;
      do_op(FPU_OP_DIV, 32'hAAAA0001, 32'h5555FFFE, 5'd1, 3, 0, 1'b0);
      do_op(FPU_OP_DIV, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd2, 2, 1, 1'b0);
      m_stale = 1'b0;

      m_delay = 20;
      req_valid = 1'b1; req_op = FPU_OP_ADD; req_a = 32'h3F800000; req_b = 32'h40000000; req_tag = 5'd30;
      seen = 0;
      while (!req_ready && seen < 100) begin
         @(negedge clk); seen++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_run", fpu_start, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ctl", {fpu_start, rsp_valid, fpu_rst, req_ready}, 4'b0000);
      chk("async_rst_a", fpu_a, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("no_rsp_after_rst", seen, 0);
      do_op(FPU_OP_ADD, 32'h41C00000, 32'h40C00000, 5'd5, 6, 0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         r_op    = 2'($urandom_range(0, 3));
         r_a     = $urandom;
         r_b     = $urandom;
         r_tag   = 5'($urandom_range(0, 31));
         r_delay = $urandom_range(1, 36);
         r_bp    = $urandom_range(0, 3);
         r_hold  = 1'($urandom_range(0, 1));
         do_op(r_op, r_a, r_b, r_tag, r_delay, r_bp, r_hold);
      end
      req_valid = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator for the fpu start/done handshake: takes one floating-point request at a time from the core pipeline, runs the fpu's per-operation reset/start sequence, and returns the result with its destination tag.
- Sits between the execute stage and the fpu instance.
- Adds a watchdog so a hung fpu cannot stall the pipeline.

Parameters:
- TIMEOUT_CYCLES, 32: maximum RUN-state cycles to wait for fpu_done before aborting.
- TAG_W, 5: width of the destination-register tag carried with each request.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  operation code (see package)
- req_a  in  32  operand A, IEEE-754 single
- req_b  in  32  operand B, IEEE-754 single
- req_tag  in  TAG_W  destination tag
- fpu_rst  out  1  per-operation reset to fpu
- fpu_start  out  1  start to fpu
- fpu_op  out  2  op to fpu
- fpu_a  out  32  operand A to fpu
- fpu_b  out  32  operand B to fpu
- fpu_r  in  32  fpu result
- fpu_done  in  1  fpu completion flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_r  out  32  result
- rsp_tag  out  TAG_W  tag of completed request
- rsp_timeout  out  1  result is watchdog abort value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state registers clear on rst.
- Reset values:
  - State is IDLE.
  - fpu_rst, fpu_start, rsp_valid, rsp_timeout are 0.
  - fpu_a, fpu_b, rsp_r are 0; fpu_op is 0; rsp_tag is 0; watchdog counter is 0.
- req_ready = (state==IDLE) and not rst. No request is accepted while rst is high.
- State machine:
  - IDLE: on req_valid && req_ready at edge N, latch op/a/b/tag into the fpu_* and tag registers; go to CLEAR.
  - CLEAR (cycle N+1): fpu_rst=1, fpu_start=0, fpu_done ignored; counter cleared; next state is RUN.
  - RUN (cycle N+2 onward): fpu_rst=0, fpu_start=1 held continuously.
    - Operands stay stable the whole time.
    - Counter increments every RUN cycle.
    - If fpu_done=1: capture rsp_r=fpu_r, rsp_timeout=0, go to RESP.
    - Else if counter == TIMEOUT_CYCLES-1: capture rsp_r=QNAN (32'h7FC00000), rsp_timeout=1, go to RESP.
    - If done and timeout occur in the same cycle, done wins.
  - RESP: fpu_start=0, rsp_valid=1. rsp_r, rsp_tag, rsp_timeout are held stable until rsp_ready=1 at an edge, then go to IDLE.
- Latency:
  - fpu_done seen in RUN cycle k gives rsp_valid from cycle k+1.
  - Minimum latency from request acceptance to rsp_valid is 3 cycles.
- Back-to-back requests: no request is accepted in the same cycle as a response handshake. Minimum one IDLE cycle between operations.
- Stale done: fpu_done high in CLEAR (left over from the previous op) must never be captured.
- Reset mid-operation: rst in any state immediately forces IDLE and reset values. The in-flight request is dropped and no response is produced.
- fpu_op/fpu_a/fpu_b keep their last values in IDLE/RESP. Only fpu_start qualifies them.

Decomposition:
- Shared package fpu_pkg holds:
  - FPU_OP_ADD=2'b00, FPU_OP_SUB=2'b01, FPU_OP_MUL=2'b10, FPU_OP_DIV=2'b11
  - FPU_QNAN=32'h7FC00000
  - state encoding IDLE/CLEAR/RUN/RESP
- One natural sub-module: fpu_issue_timer, a loadable watchdog counter with clear, enable, and an expired flag. Its width is $clog2(TIMEOUT_CYCLES)+1.

Test Plan:
- Add 24+6, with a real fpu or a model asserting done after 12 cycles: A=0x41C00000, B=0x40C00000, op=00, tag=7 -> rsp_r=0x41F00000, rsp_tag=7, rsp_timeout=0. Check fpu_rst is exactly 1 cycle wide and immediately followed by fpu_start.
- Add 0.75+2.25 then 10.75+1.15 back-to-back, with req_valid held high -> responses 0x40400000, then 0x413E6666, in order. req_ready is low throughout each operation and there is at least one IDLE cycle between them.
- Watchdog: fpu model never asserts done, TIMEOUT_CYCLES=32 -> rsp_valid exactly 32 cycles after RUN entry, rsp_r=0x7FC00000, rsp_timeout=1, fpu_start drops.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_r/rsp_tag stable, req_ready=0. Transition to IDLE on the first rsp_ready=1 edge.
- Stale done: model keeps fpu_done=1 until it sees fpu_rst -> the second request returns its own result, not the previous R.
- Reset mid-RUN: assert rst 4 cycles into RUN -> fpu_start and rsp_valid fall immediately (asynchronously), no response is emitted, and the next request completes normally.
